// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen -- programmable enable-pulse generator.
//
// Divides clk down to single-cycle en_o ticks with a period of div+1 clocks.
// The generator runs either continuously until stopped, or as a burst of a
// fixed number of ticks. It is intended to drive the en input of a downstream
// counter. Run parameters are captured when a run starts and held until it ends.
//
// Ports:
//   clk           in   clock; all state changes on the rising edge
//   rst_n         in   asynchronous active-low reset
//   start_i       in   one-cycle request; begins a run when idle
//   stop_i        in   one-cycle request; aborts a run (wins over start_i)
//   mode_i        in   0 = continuous, 1 = burst; sampled with start_i
//   div_i         in   prescale value; sampled with start_i
//   burst_len_i   in   ticks per burst; sampled with start_i
//   en_o          out  one-cycle tick to the downstream counter
//   busy_o        out  high while a run is in progress
//   done_o        out  one-cycle pulse after the last tick of a completed burst
//   ticks_left_o  out  ticks remaining in the burst; 0 in continuous mode/idle
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV_W   = 8,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               mode_i,
    input  logic [DIV_W-1:0]   div_i,
    input  logic [BURST_W-1:0] burst_len_i,
    output logic               en_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [BURST_W-1:0] ticks_left_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   cnt_q;
    logic               mode_q;
    logic               done_q;
    logic [BURST_W-1:0] ticks_left_q;
    logic               tick;

    // The tick is decoded purely from registers, so nothing on the input side
    // can reach en_o combinationally. A tick decoded in the same cycle as
    // stop_i is therefore still emitted.
    assign tick = (state_q == ST_RUN) && (cnt_q == div_q);

    // NOTE: every register below is assigned with non-blocking (<=) so all
    // updates use the values from before the edge; blocking assignments here
    // would make later statements see half-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            done_q       <= 1'b0;
            ticks_left_q <= '0;
        end else begin
            // done is a single-cycle pulse unless re-asserted below.
            done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // stop_i wins over a simultaneous start_i.
                    if (start_i && !stop_i) begin
                        if (mode_i && (burst_len_i == '0)) begin
                            // Zero-length burst: complete immediately, no ticks.
                            done_q <= 1'b1;
                        end else begin
                            state_q      <= ST_RUN;
                            div_q        <= div_i;
                            mode_q       <= mode_i;
                            cnt_q        <= '0;
                            ticks_left_q <= mode_i ? burst_len_i : '0;
                        end
                    end
                end

                ST_RUN: begin
                    // start_i is deliberately ignored while running.
                    if (stop_i) begin
                        state_q      <= ST_IDLE;
                        cnt_q        <= '0;
                        ticks_left_q <= '0;
                    end else begin
                        // Prescaler wraps on the tick, so cnt_q never exceeds div_q.
                        cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);

                        if (tick && mode_q) begin
                            if (ticks_left_q == BURST_W'(1)) begin
                                state_q      <= ST_IDLE;
                                ticks_left_q <= '0;
                                done_q       <= 1'b1;
                            end else begin
                                ticks_left_q <= ticks_left_q - BURST_W'(1);
                            end
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign en_o         = tick;
    assign busy_o       = (state_q == ST_RUN);
    assign done_o       = done_q;
    assign ticks_left_o = ticks_left_q;

endmodule

// File: tb/tb_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_tick_gen -- self-checking bench for tick_gen.
//
// Each command issued to the DUT is translated into expected output events
// (en ticks and done pulses, each tagged with the clock cycle in which it must
// appear) using plain arithmetic on the run parameters. Those events go into a
// queue; an independent monitor on the falling edge pops one whenever the DUT
// shows en_o or done_o and compares the cycle. The same monitor checks busy_o
// and ticks_left_o every cycle against the expected run window, and counts
// en_o pulses in a 4-bit downstream counter model.
// -----------------------------------------------------------------------------
module tb_tick_gen;

    localparam int DIV_W   = 8;
    localparam int BURST_W = 4;

    logic               clk         = 1'b0;
    logic               rst_n       = 1'b0;
    logic               start_i     = 1'b0;
    logic               stop_i      = 1'b0;
    logic               mode_i      = 1'b0;
    logic [DIV_W-1:0]   div_i       = '0;
    logic [BURST_W-1:0] burst_len_i = '0;
    logic               en_o;
    logic               busy_o;
    logic               done_o;
    logic [BURST_W-1:0] ticks_left_o;

    // Cycle index: number of rising edges seen so far.
    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    // Expected run window [win_start, win_end) in cycle indices.
    int   win_start = 0;
    int   win_end   = 0;
    int   win_per   = 1;
    int   win_len   = 0;
    logic win_burst = 1'b0;

    // Downstream 4-bit counter fed by en_o.
    logic [3:0] dcount = '0;

    typedef struct {
        bit is_done;
        int cyc;
    } ev_t;

    ev_t exp_q[$];

    tick_gen #(
        .DIV_W   (DIV_W),
        .BURST_W (BURST_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .mode_i       (mode_i),
        .div_i        (div_i),
        .burst_len_i  (burst_len_i),
        .en_o         (en_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .ticks_left_o (ticks_left_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_ev(input bit is_done, input int c);
        ev_t ev;
        ev.is_done = is_done;
        ev.cyc     = c;
        exp_q.push_back(ev);
    endfunction

    task automatic match_ev(input bit is_done);
        ev_t ev;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_%s: got pulse, expected none (cycle %0d)",
                     is_done ? "done" : "en", cyc);
        end else begin
            ev = exp_q.pop_front();
            check(is_done ? "done_kind" : "en_kind", int'(is_done), int'(ev.is_done));
            check(is_done ? "done_cycle" : "en_cycle", cyc, ev.cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin : monitor
        bit in_win;
        int exp_tl;
        in_win = (cyc >= win_start) && (cyc < win_end);
        exp_tl = (in_win && win_burst) ? win_len - (cyc - win_start) / win_per : 0;
        check("busy", int'(busy_o), int'(in_win));
        check("ticks_left", int'(ticks_left_o), exp_tl);
        if (en_o === 1'b1) begin
            dcount = dcount + 4'd1;
            match_ev(1'b0);
        end
        if (done_o === 1'b1) begin
            match_ev(1'b1);
        end
    end

    // Issue one run. stop_at > 0: stop is sampled stop_at edges after the
    // start edge. poke: pulse start mid-run and in the final-tick cycle.
    // rst_at > 0: assert async reset rst_at cycles into the run.
    task automatic issue(input logic m, input int d, input int n,
                         input int stop_at_in, input bit poke, input int rst_at);
        int e;
        int per;
        int full;
        int len;
        int stop_at;
        int nt;
        bit pk;
        bit aborted;
        stop_at = stop_at_in;
        per     = d + 1;
        nt      = 0;
        aborted = 1'b0;
        @(posedge clk); #1;
        e           = cyc + 1;
        start_i     = 1'b1;
        stop_i      = 1'b0;
        mode_i      = m;
        div_i       = DIV_W'(d);
        burst_len_i = BURST_W'(n);
        dcount      = '0;
        if (m && n == 0) begin
            len = 0;
            push_ev(1'b1, e);
            win_start = e;
            win_end   = e;
        end else begin
            full = m ? n * per : stop_at;
            if (m && stop_at >= full) stop_at = 0;
            len = (stop_at > 0) ? stop_at : full;
            for (int c = e + d; c < e + len; c += per) begin
                push_ev(1'b0, c);
                nt++;
            end
            if (m && stop_at == 0) push_ev(1'b1, e + len);
            win_burst = m;
            win_len   = n;
            win_per   = per;
            win_start = e;
            win_end   = e + len;
        end
        pk = poke && (len > 0);

        while (cyc < e + len + 3) begin
            @(posedge clk); #1;
            start_i     = pk && ((cyc == e + len / 2) || (cyc == e + len - 1));
            stop_i      = (stop_at > 0) && (cyc == e + stop_at - 1);
            div_i       = DIV_W'($urandom);
            mode_i      = 1'($urandom);
            burst_len_i = BURST_W'($urandom);
            if (rst_at > 0 && cyc == e + rst_at) begin
                #1;
                rst_n = 1'b0;
                exp_q.delete();
                win_start = 0;
                win_end   = 0;
                #1;
                check("rst_en", int'(en_o), 0);
                check("rst_busy", int'(busy_o), 0);
                check("rst_done", int'(done_o), 0);
                check("rst_ticks_left", int'(ticks_left_o), 0);
                repeat (2) @(posedge clk);
                #3;
                rst_n   = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        start_i = 1'b0;
        stop_i  = 1'b0;
        check("events_pending", exp_q.size(), 0);
        if (!aborted) check("downstream_count", int'(dcount), nt % 16);
    endtask

    // start and stop together while idle: nothing must happen.
    task automatic start_stop_idle(input logic m, input int n);
        @(posedge clk); #1;
        start_i     = 1'b1;
        stop_i      = 1'b1;
        mode_i      = m;
        div_i       = '0;
        burst_len_i = BURST_W'(n);
        @(posedge clk); #1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        dcount  = '0;
        repeat (6) @(posedge clk);
        #1;
        check("ss_idle_busy", int'(busy_o), 0);
        check("ss_idle_events", exp_q.size(), 0);
        check("ss_idle_count", int'(dcount), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: got no completion, expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int m;
        int d;
        int n;
        int s;
        int p;

        #3;
        check("reset_en", int'(en_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_done", int'(done_o), 0);
        check("reset_ticks_left", int'(ticks_left_o), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        issue(1'b1, 3, 4, 0, 1'b0, 0);     // burst: 4 ticks every 4th cycle
        issue(1'b0, 0, 0, 10, 1'b0, 0);    // continuous full rate, stop after 10
        issue(1'b0, 0, 0, 20, 1'b0, 0);    // longer run, downstream wraps past 15
        issue(1'b1, 2, 8, 9, 1'b0, 0);     // abort after the 3rd tick
        issue(1'b1, 5, 0, 0, 1'b0, 0);     // zero-length burst
        issue(1'b1, 3, 3, 0, 1'b1, 0);     // start during run and at last tick
        issue(1'b0, 2, 0, 15, 1'b1, 0);    // continuous with start pokes
        start_stop_idle(1'b0, 0);
        start_stop_idle(1'b1, 0);
        start_stop_idle(1'b1, 5);
        issue(1'b1, 255, 2, 0, 1'b0, 0);   // maximum divider
        issue(1'b1, 0, 15, 0, 1'b0, 0);    // maximum burst at full rate
        issue(1'b1, 3, 8, 0, 1'b0, 10);    // async reset mid-burst
        repeat (12) @(posedge clk);
        #1;
        check("post_reset_idle_events", exp_q.size(), 0);
        check("post_reset_busy", int'(busy_o), 0);

        for (int i = 0; i < 25; i++) begin
            m = int'($urandom_range(0, 1));
            d = int'($urandom_range(0, 6));
            n = int'($urandom_range(0, 15));
            p = int'($urandom_range(0, 1));
            if (m == 1) s = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n * (d + 1) + 2)) : 0;
            else        s = int'($urandom_range(1, 40));
            issue(m[0], d, n, s, p[0], 0);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
# tick_gen

Programmable enable-pulse generator sitting directly upstream of the 4-bit `counter` block and driving its `en` input. It divides `clk` down to single-cycle `en` ticks at a software-selected rate, either free-running or as a burst of a set number of ticks. A run/stop state machine with `start`, `stop`, `busy` and `done` lets a controller issue "count N events at rate R" and know when the burst has completed.

## Interface
- `DIV_W`, 8: prescaler width; tick period is `div`+1 clocks.
- `BURST_W`, 4: burst-length width, matching the downstream counter width.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; begins a run when idle.
- `stop`  in  1  one-cycle request; aborts a run.
- `mode`  in  1  0 = continuous, 1 = burst; sampled with `start`.
- `div`  in  DIV_W  prescale value; sampled with `start`.
- `burst_len`  in  BURST_W  ticks per burst; sampled with `start`.
- `en`  out  1  one-cycle tick to the downstream counter.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a burst completes normally.
- `ticks_left`  out  BURST_W  ticks remaining in the current burst; 0 in continuous mode and when idle.

## Operation
- States: IDLE, RUN.
- Registers: `div_q`, `mode_q`, `ticks_left`, prescaler `cnt` (DIV_W bits), `done`.
- IDLE → RUN when `start`=1 and `stop`=0.
  - Latch `div_q`=`div`, `mode_q`=`mode`, `cnt`=0.
  - `ticks_left` = `burst_len` if `mode`=1, else 0.
- Zero-length burst: `start` with `mode`=1 and `burst_len`=0 stays in IDLE and pulses `done` on the next cycle. No `en` is produced.
- RUN behaviour:
  - `en` = (state==RUN) && (`cnt`==`div_q`). It is decoded from registers only; there is no combinational path from any input to `en`.
  - Each cycle: `cnt` ← 0 if `en`, else `cnt`+1.
  - Burst mode: on each `en`, `ticks_left` decrements. When `en`=1 and `ticks_left`==1, the next state is IDLE, `ticks_left`=0 and `done`=1 for one cycle.
  - Continuous mode: RUN persists until `stop`.
- `stop`=1 in RUN → IDLE at the next edge; `cnt` and `ticks_left` clear to 0; no `done` pulse.
  - A tick already decoded in the `stop` cycle is still emitted.
- `start` is ignored in RUN, including a `start` in the same cycle as the final burst tick. `start` and `stop` together in IDLE: `stop` wins, so the block stays in IDLE.
- `div_q` is unaffected by changes to `div` during RUN.
- Asynchronous reset at any time, including mid-burst: state = IDLE, all registers 0.
- Reset values: `en`=0, `busy`=0, `done`=0, `ticks_left`=0.

## Timing
- `start` is sampled at edge E. The first `en` is high in the cycle after edge E+`div_q`.
  - With `div`=0, `en` is high in the cycle immediately after E, and on every cycle thereafter.
- Tick period is exactly `div_q`+1 clocks. Ticks are never back-to-back unless `div_q`=0.
- `busy` rises at E and falls at the edge that ends the last burst tick or accepts `stop`.
- `done` is high for the single cycle immediately after the last `en`. It coincides with `busy`=0.
- A burst of length N with divider D occupies exactly N·(D+1) cycles of `busy`.
- `div_q` at its maximum (2^DIV_W−1): `cnt` reaches the all-ones value and wraps to 0 on the tick; it never overflows.

## Test plan
- **Reset:** `rst_n` low asynchronously mid-RUN → `en`/`busy`/`done`/`ticks_left` = 0 immediately. After release, the block stays in IDLE with no `en` until `start`.
- **Burst:** `mode`=1, `div`=3, `burst_len`=4, pulse `start` →
  - `en` high every 4th cycle, 4 times.
  - `ticks_left` steps 4,3,2,1,0.
  - `done` pulses once, 16 cycles after `start`.
  - Downstream counter reads 4.
- **Continuous at full rate:** `mode`=0, `div`=0 → `en` high every cycle. Pulse `stop` after 10 cycles → `busy` falls; no `done`; counter reads 10 (wraps correctly past 15 on longer runs).
- **Abort:** `mode`=1, `div`=2, `burst_len`=8, `stop` after the 3rd tick → IDLE, `ticks_left`=0, no `done`, counter holds 3.
- **Zero-length burst:** `mode`=1, `burst_len`=0, `start` → `busy` stays 0, no `en`, `done` pulses once on the next cycle.
- **Simultaneous events:**
  - `start` during RUN → no effect.
  - `start`+`stop` in IDLE → stays IDLE.
  - `div` changed mid-run → tick period unchanged.
